// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - Kyber arithmetic constants and conditional-subtract helper
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int BARRETT_M = 5039;
  localparam int BARRETT_K = 24;
  localparam int COEF_W    = 12;

  typedef logic [COEF_W-1:0] coef_t;

  // Maps x in [0, 2q) onto [0, q).
  function automatic coef_t csub(input logic [COEF_W:0] x);
    if (x >= (COEF_W+1)'(KYBER_Q)) begin
      return x[COEF_W-1:0] - COEF_W'(KYBER_Q);
    end
    return x[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/mod_mul_barrett_pipe_if.sv
// rtl/mod_mul_barrett_pipe_if.sv - valid/ready operand and result bundle for the modular multiplier
interface mod_mul_barrett_pipe_if #(
  parameter int DATA_WIDTH = kyber_pkg::COEF_W,
  parameter int TAG_WIDTH  = 16
);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output flush, in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag
  );

  modport slave (
    input  flush, in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag
  );

endinterface

// File: rtl/mod_csub.sv
// rtl/mod_csub.sv - combinational conditional subtract of the modulus, shared with the adder
module mod_csub
  import kyber_pkg::*;
#(
  parameter int W = COEF_W,
  parameter int Q = KYBER_Q
) (
  input  logic [W:0]   x,
  output logic [W-1:0] y
);

  // Valid for x < 2Q: the low W bits of x-Q are exact when x >= Q.
  always_comb begin
    if (x >= (W+1)'(Q)) begin
      y = x[W-1:0] - W'(Q);
    end else begin
      y = x[W-1:0];
    end
  end

endmodule

// File: rtl/mod_mul_barrett_pipe.sv
// rtl/mod_mul_barrett_pipe.sv - three-stage Barrett modular multiplier with bubble-collapsing flow control
module mod_mul_barrett_pipe #(
  parameter int DATA_WIDTH = kyber_pkg::COEF_W,
  parameter int MODULUS    = kyber_pkg::KYBER_Q,
  parameter int BARRETT_M  = kyber_pkg::BARRETT_M,
  parameter int BARRETT_K  = kyber_pkg::BARRETT_K,
  parameter int TAG_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mod_mul_barrett_pipe_if.slave bus
);

  localparam int DW  = DATA_WIDTH;
  localparam int PW  = 2 * DW;
  localparam int MW  = $clog2(BARRETT_M + 1);
  localparam int PMW = PW + MW;
  localparam int TW  = DW + 1;
  localparam int RW  = PW + 1;

  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [PW-1:0]        p1_q, p1_d, p2_q, p2_d;
  logic [TW-1:0]        t2_q, t2_d;
  logic [DW-1:0]        res_q, res_d;
  logic [TAG_WIDTH-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;

  logic                 adv1, adv2, adv3, accept;
  logic [PMW-1:0]       pm;
  logic [RW-1:0]        tq;
  logic [TW-1:0]        r;
  logic [DW-1:0]        r_red;

  mod_csub #(.W(DW), .Q(MODULUS)) u_csub (
    .x (r),
    .y (r_red)
  );

  always_comb begin
    adv3   = !v3_q | bus.out_ready;
    adv2   = !v2_q | adv3;
    adv1   = !v1_q | adv2;
    accept = bus.in_valid & adv1 & !bus.flush;

    pm = PMW'(p1_q) * PMW'(BARRETT_M);
    tq = RW'(t2_q) * RW'(MODULUS);
    // Barrett quotient may be one short, so r lands in [0, 2q) and fits DW+1 bits.
    r  = TW'(RW'(p2_q) - tq);

    v1_d = v1_q;  p1_d = p1_q;  tag1_d = tag1_q;
    v2_d = v2_q;  p2_d = p2_q;  t2_d = t2_q;  tag2_d = tag2_q;
    v3_d = v3_q;  res_d = res_q;  tag3_d = tag3_q;

    if (adv1) begin
      v1_d   = accept;
      p1_d   = PW'(bus.a) * PW'(bus.b);
      tag1_d = bus.in_tag;
    end
    if (adv2) begin
      v2_d   = v1_q;
      p2_d   = p1_q;
      t2_d   = TW'(pm >> BARRETT_K);
      tag2_d = tag1_q;
    end
    if (adv3) begin
      v3_d   = v2_q;
      res_d  = r_red;
      tag3_d = tag2_q;
    end
    if (bus.flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      p1_q   <= '0;
      p2_q   <= '0;
      t2_q   <= '0;
      res_q  <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      t2_q   <= t2_d;
      res_q  <= res_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      tag3_q <= tag3_d;
    end
  end

  assign bus.in_ready  = adv1 & !bus.flush;
  assign bus.out_valid = v3_q;
  assign bus.result    = res_q;
  assign bus.out_tag   = tag3_q;

endmodule

// File: tb/tb_mod_mul_barrett_pipe.sv
// tb/tb_mod_mul_barrett_pipe.sv - directed and randomized self-checking bench for mod_mul_barrett_pipe
module tb_mod_mul_barrett_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mod_mul_barrett_pipe_if #(.DATA_WIDTH(12), .TAG_WIDTH(16)) bus ();

  mod_mul_barrett_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_wait(input logic [11:0] va, input logic [11:0] vb, input logic [15:0] vtag,
                           input logic [11:0] exp, input string nm);
    int cyc;
    bus.in_valid  = 1'b1;
    bus.a         = va;
    bus.b         = vb;
    bus.in_tag    = vtag;
    bus.out_ready = 1'b1;
    #1;
    check({nm, "_in_ready"}, 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 10) begin
      step();
      cyc++;
    end
    check({nm, "_latency"}, cyc, 3);
    check({nm, "_result"}, 32'(bus.result), 32'(exp));
    check({nm, "_tag"}, 32'(bus.out_tag), 32'(vtag));
    step();
  endtask

  initial begin
    int outs, first_j, last_j, n_acc, idx, sent, got, cyc, prod;
    logic [27:0] sb[$];
    logic [27:0] e;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_out_tag", 32'(bus.out_tag), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);

    send_wait(12'd3328, 12'd3328, 16'h0001, 12'd1, "qm1_sq");
    send_wait(12'd17, 12'd1729, 16'h0002, 12'd2761, "v17x1729");
    send_wait(12'd0, 12'd1234, 16'h0003, 12'd0, "zero");
    send_wait(12'd4095, 12'd4095, 16'h0004, 12'd852, "max_sq");

    // Back-to-back stream
    outs = 0; first_j = -1; last_j = -1;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (j < 8) begin
        bus.in_valid = 1'b1;
        bus.a = 12'(j + 1);
        bus.b = 12'(1000 + j);
        bus.in_tag = 16'(100 + j);
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (bus.out_valid) begin
        check("b2b_tag", 32'(bus.out_tag), 32'(100 + outs));
        check("b2b_result", 32'(bus.result), 32'(((outs + 1) * (1000 + outs)) % 3329));
        if (first_j < 0) first_j = j;
        last_j = j;
        outs++;
      end
    end
    check("b2b_count", outs, 8);
    check("b2b_first", first_j, 2);
    check("b2b_consecutive", last_j - first_j, 7);

    // Backpressure fill and stall
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int j = 0; j < 5; j++) begin
      bus.in_valid = 1'b1;
      bus.a = 12'(50 + n_acc);
      bus.b = 12'd60;
      bus.in_tag = 16'(200 + n_acc);
      #1;
      if (bus.in_ready) n_acc++;
      step();
    end
    check("stall_accepted", n_acc, 3);
    check("stall_in_ready", 32'(bus.in_ready), 0);
    check("stall_out_valid", 32'(bus.out_valid), 1);
    for (int j = 0; j < 2; j++) begin
      check("stall_result", 32'(bus.result), 3000);
      check("stall_tag", 32'(bus.out_tag), 200);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid) begin
        check("drain_tag", 32'(bus.out_tag), 32'(200 + idx));
        check("drain_result", 32'(bus.result), 32'(((50 + idx) * 60) % 3329));
        idx++;
      end
      step();
    end
    check("drain_count", idx, 3);

    // Flush with two items in flight
    bus.in_valid = 1'b1; bus.a = 12'd5; bus.b = 12'd7; bus.in_tag = 16'd300;
    step();
    bus.in_tag = 16'd301;
    step();
    bus.flush = 1'b1; bus.in_tag = 16'd399;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 0);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    outs = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid) outs++;
      step();
    end
    check("flush_no_output", outs, 0);
    send_wait(12'd9, 12'd11, 16'd310, 12'd99, "post_flush");

    // Asynchronous reset while holding a valid output
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 12'd17; bus.b = 12'd1729; bus.in_tag = 16'h0055;
    repeat (3) step();
    check("pre_rst_valid", 32'(bus.out_valid), 1);
    check("pre_rst_result", 32'(bus.result), 2761);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 0);
    check("async_rst_result", 32'(bus.result), 0);
    check("async_rst_tag", 32'(bus.out_tag), 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    check("post_rst_valid", 32'(bus.out_valid), 0);

    // Random stream against an arithmetic reference with random backpressure
    sent = 0; got = 0; cyc = 0;
    while ((sent < 10000 || got < sent) && cyc < 60000) begin
      bus.in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      bus.a         = 12'($urandom_range(0, 4095));
      bus.b         = 12'($urandom_range(0, 4095));
      bus.in_tag    = 16'(sent);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("rnd_spurious", 32'(bus.out_valid), 0);
        end else begin
          e = sb.pop_front();
          check("rnd_result", 32'(bus.result), 32'(e[11:0]));
          check("rnd_tag", 32'(bus.out_tag), 32'(e[27:12]));
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        prod = int'(bus.a) * int'(bus.b);
        sb.push_back({bus.in_tag, 12'(prod % 3329)});
        sent++;
      end
      step();
      cyc++;
    end
    check("rnd_sent", sent, 10000);
    check("rnd_received", got, 10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
